uart_tx_sched: RTL

Round-robin transmit scheduler that shares one serial TX line among `NUM_REQ` byte producers. It consumes the one-clock-wide 16x oversample tick from the baud generator (`BCLK`). It arbitrates among pending requests, latches the winning byte and serialises it as 8N1 (start bit, `DATA_BITS` data bits LSB first, one stop bit). Each bit lasts exactly `OVERSAMPLE` ticks. It sits between the baud generator and the board-level TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_sched_rr_arbiter.sv | 39 +++
 rtl/uart_tx_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  // Frame sequencing states of the transmit scheduler.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Ticks per serial bit expected from the baud generator.
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Level driven on the line between frames and during the stop bit.
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the pointer register.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id
);

  logic          found;
  logic [IW:0]   pos;

  // Scan upward from ptr with wrap-around; first asserted request wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    pos    = '0;
    if (en) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        pos = (IW+1)'(ptr) + (IW+1)'(k);
        if (pos >= (IW+1)'(NUM_REQ)) begin
          pos = pos - (IW+1)'(NUM_REQ);
        end
        if (!found && req[IW'(pos)]) begin
          found           = 1'b1;
          gnt[IW'(pos)]   = 1'b1;
          gnt_id          = IW'(pos);
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 serial TX line among NUM_REQ producers.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bclk,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     gnt_id,
  output logic                           busy,
  output logic                           txd
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(NUM_REQ - 1);

  state_t                state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         next_ptr;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  sel_byte;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IW-1:0]         arb_id;
  logic                  arb_en;
  logic                  bit_end;

  // Arbitrate only while the line is free.
  assign arb_en = (state == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Byte owned by the winning requester.
  assign sel_byte = DATA_BITS'(data >> (arb_id * DATA_BITS));

  // A bit ends on the tick that completes its OVERSAMPLE-tick window.
  assign bit_end = bclk && (tick_cnt == TICK_LAST);

  // Priority moves to the requester just after the winner.
  always_comb begin
    next_ptr = arb_id + IW'(1);
    if (arb_id == ID_LAST) begin
      next_ptr = '0;
    end
  end

  // Frame sequencer with registered line, grant and busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      txd      <= IDLE_LEVEL;
    end else begin
      gnt <= '0;
      if ((state != IDLE) && bclk) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
      end
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            gnt      <= arb_gnt;
            gnt_id   <= arb_id;
            shreg    <= sel_byte;
            ptr      <= next_ptr;
            tick_cnt <= '0;
            busy     <= 1'b1;
            txd      <= ~IDLE_LEVEL;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            txd     <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              txd   <= IDLE_LEVEL;
              state <= STOP;
            end else begin
              txd   <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_sched
